// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode type and tick-count helper for the LED pattern generator
package led_pattern_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'b00,
      LED_ON      = 2'b01,
      LED_BLINK   = 2'b10,
      LED_BREATHE = 2'b11
   } led_mode_t;

   // Rounded so that products like 1e3*4e-3 cannot truncate to one below.
   function automatic integer tick_count(input real f, input real t);
      return $rtoi(f * t + 0.5);
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control and LED-drive bundle between board control and the generator
interface led_pattern_gen_if #(
   parameter int NUM_LEDS  = 4,
   parameter int PWM_WIDTH = 8
);
   logic                            enable;
   logic                            sync;
   logic [2*NUM_LEDS-1:0]           mode;
   logic [PWM_WIDTH*NUM_LEDS-1:0]   duty;
   logic                            tick;
   logic [NUM_LEDS-1:0]             led;

   modport master (output enable, sync, mode, duty, input tick, led);
   modport slave  (input enable, sync, mode, duty, output tick, led);
endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - shared prescaler producing a registered one-cycle tick every TICK_COUNT clocks
module led_tick_gen #(
   parameter int TICK_COUNT = 65000
) (
   input  logic clk,
   input  logic rstN,
   input  logic i_enable,
   input  logic i_sync,
   output logic o_tick
);
   localparam int               CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_COUNT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   if (TICK_COUNT < 2) begin : g_bad_tick_count
      $error("led_tick_gen: TICK_COUNT must be at least 2");
   end

   // sync outranks the wrap so a coincident restart never emits a stray tick
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (i_sync) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!i_enable) begin
         r_tick <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;
endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver with OFF/ON/BLINK/BREATHE modes and PWM dimming
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter real                 CLK_FREQUENCY = 65.0e6,
   parameter real                 TICK_PERIOD   = 1.0e-3,
   parameter int                  BLINK_TICKS   = 250,
   parameter int                  NUM_LEDS      = 4,
   parameter int                  PWM_WIDTH     = 8,
   parameter logic [NUM_LEDS-1:0] BLINK_INVERT  = '0
) (
   input logic              clk,
   input logic              rstN,
   led_pattern_gen_if.slave bus
);
   localparam int                   TICK_COUNT = tick_count(CLK_FREQUENCY, TICK_PERIOD);
   localparam int                   BC_W       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BC_W-1:0]      BLINK_LAST = BC_W'(BLINK_TICKS - 1);
   localparam logic [PWM_WIDTH-1:0] LVL_MAX    = '1;

   if (BLINK_TICKS < 1) begin : g_bad_blink_ticks
      $error("led_pattern_gen: BLINK_TICKS must be at least 1");
   end

   function automatic logic pwm_on(input logic [PWM_WIDTH-1:0] d, input logic [PWM_WIDTH-1:0] cnt);
      return (&d) | (cnt < d);
   endfunction

   logic                 w_tick;
   logic [PWM_WIDTH-1:0] r_pwm_cnt;
   logic [BC_W-1:0]      r_blink_cnt;
   logic                 r_blink_state;
   logic [PWM_WIDTH-1:0] r_level;
   logic                 r_dir_down;
   logic [NUM_LEDS-1:0]  r_led;
   logic [NUM_LEDS-1:0]  w_led_next;

   led_tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick_gen (
      .clk      (clk),
      .rstN     (rstN),
      .i_enable (bus.enable),
      .i_sync   (bus.sync),
      .o_tick   (w_tick)
   );

   // Shared phase state: every channel reads the same blink/breathe position.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN || bus.sync) begin
         r_pwm_cnt     <= '0;
         r_blink_cnt   <= '0;
         r_blink_state <= 1'b0;
         r_level       <= '0;
         r_dir_down    <= 1'b0;
      end else if (bus.enable) begin
         r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
         if (w_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt   <= '0;
               r_blink_state <= ~r_blink_state;
            end else begin
               r_blink_cnt <= r_blink_cnt + BC_W'(1);
            end
            if (!r_dir_down && r_level == LVL_MAX) begin
               r_level    <= LVL_MAX - PWM_WIDTH'(1);
               r_dir_down <= 1'b1;
            end else if (r_dir_down && r_level == '0) begin
               r_level    <= PWM_WIDTH'(1);
               r_dir_down <= 1'b0;
            end else if (r_dir_down) begin
               r_level <= r_level - PWM_WIDTH'(1);
            end else begin
               r_level <= r_level + PWM_WIDTH'(1);
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_mode_t            w_mode;
      logic [PWM_WIDTH-1:0] w_duty;
      assign w_mode = led_mode_t'(bus.mode[2*i +: 2]);
      assign w_duty = bus.duty[PWM_WIDTH*i +: PWM_WIDTH];
      assign w_led_next[i] =
         (w_mode == LED_ON)      ? pwm_on(w_duty, r_pwm_cnt) :
         (w_mode == LED_BLINK)   ? ((r_blink_state ^ BLINK_INVERT[i]) & pwm_on(w_duty, r_pwm_cnt)) :
         (w_mode == LED_BREATHE) ? pwm_on(r_level, r_pwm_cnt) :
                                   1'b0;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_led <= '0;
      end else begin
         r_led <= bus.enable ? w_led_next : '0;
      end
   end

   assign bus.tick = w_tick;
   assign bus.led  = r_led;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;
   import led_pattern_pkg::*;

   localparam int N = 2;
   localparam int W = 3;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   led_pattern_gen_if #(.NUM_LEDS(N), .PWM_WIDTH(W)) bus ();

   led_pattern_gen #(
      .CLK_FREQUENCY (1.0e3),
      .TICK_PERIOD   (4.0e-3),
      .BLINK_TICKS   (2),
      .NUM_LEDS      (N),
      .PWM_WIDTH     (W),
      .BLINK_INVERT  (2'b10)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   typedef struct {
      led_mode_t   m0;
      led_mode_t   m1;
      logic [2:0]  d0;
      logic [2:0]  d1;
      int          h0;
      int          h1;
   } on_vec_t;

   on_vec_t tbl[6];
   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
      end
   endtask

   task automatic step();
      @(negedge clk);
      k++;
   endtask

   function automatic int tri_lvl(input int n);
      int m;
      m = n % 14;
      return (m <= 7) ? m : 14 - m;
   endfunction

   // led in BREATHE k clocks after a restart: level after k-1 edges vs pwm count (k-1)%8
   function automatic logic breathe_led(input int kk);
      int n;
      int l;
      if (kk < 1) return 1'b0;
      n = (kk >= 2) ? (kk - 2) / 4 : 0;
      l = tri_lvl(n);
      return (l == 7) || (((kk - 1) % 8) < l);
   endfunction

   function automatic logic blink_led0(input int kk);
      return (kk >= 10) && (((kk - 10) % 16) < 8);
   endfunction

   function automatic logic tick_exp(input int kk);
      return (kk > 0) && (kk % 4 == 0);
   endfunction

   task automatic do_reset();
      rstN       = 1'b0;
      bus.sync   = 1'b0;
      bus.enable = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_led", 32'(bus.led), 32'd0);
      rstN = 1'b1;
      k    = 0;
   endtask

   task automatic restart_check(input string tag);
      bus.mode = '0;
      bus.duty = '0;
      do_reset();
      for (int j = 0; j < 9; j++) begin
         step();
         check({tag, "_tick"}, 32'(bus.tick), 32'(tick_exp(k)));
         check({tag, "_led"}, 32'(bus.led), 32'd0);
      end
   endtask

   task automatic check_breathe(input string tag);
      logic b;
      b = breathe_led(k);
      check({tag, "_led"}, 32'(bus.led), 32'({b, b}));
      check({tag, "_tick"}, 32'(bus.tick), 32'(tick_exp(k)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int h0;
      int h1;
      logic b;

      bus.enable = 1'b1;
      bus.sync   = 1'b0;
      bus.mode   = '0;
      bus.duty   = '0;

      tbl[0] = '{LED_ON,  LED_ON,  3'd3, 3'd3, 3, 3};
      tbl[1] = '{LED_ON,  LED_ON,  3'd0, 3'd7, 0, 8};
      tbl[2] = '{LED_OFF, LED_ON,  3'd7, 3'd1, 0, 1};
      tbl[3] = '{LED_ON,  LED_OFF, 3'd6, 3'd2, 6, 0};
      tbl[4] = '{LED_ON,  LED_ON,  3'd1, 3'd4, 1, 4};
      tbl[5] = '{LED_ON,  LED_ON,  3'd7, 3'd5, 8, 5};

      // Reset release and tick cadence with all channels off
      do_reset();
      for (int j = 0; j < 12; j++) begin
         step();
         check("t1_tick", 32'(bus.tick), 32'(tick_exp(k)));
         check("t1_led", 32'(bus.led), 32'd0);
      end

      // ON-mode duty table, counted over 8 consecutive clocks
      for (int i = 0; i < 6; i++) begin
         bus.mode = {tbl[i].m1, tbl[i].m0};
         bus.duty = {tbl[i].d1, tbl[i].d0};
         step();
         h0 = 0;
         h1 = 0;
         repeat (8) begin
            h0 += int'(bus.led[0]);
            h1 += int'(bus.led[1]);
            step();
         end
         check($sformatf("on_ch0_v%0d", i), 32'(h0), 32'(tbl[i].h0));
         check($sformatf("on_ch1_v%0d", i), 32'(h1), 32'(tbl[i].h1));
      end

      // Blink with channel 1 in antiphase, then async reset mid-blink
      bus.mode = {LED_BLINK, LED_BLINK};
      bus.duty = {3'd7, 3'd7};
      do_reset();
      for (int j = 0; j < 40; j++) begin
         step();
         b = blink_led0(k);
         check("blink_led", 32'(bus.led), 32'({~b, b}));
      end
      #2 rstN = 1'b0;
      #1;
      check("blink_arst_led", 32'(bus.led), 32'd0);
      check("blink_arst_tick", 32'(bus.tick), 32'd0);
      restart_check("blink_restart");

      // Breathe triangle over a full period and beyond
      bus.mode = {LED_BREATHE, LED_BREATHE};
      do_reset();
      for (int j = 0; j < 59; j++) begin
         step();
         check_breathe("breathe");
      end

      // sync lands on the edge that would otherwise raise tick
      bus.sync = 1'b1;
      step();
      check("sync_tick", 32'(bus.tick), 32'd0);
      bus.sync = 1'b0;
      k = 0;
      for (int j = 0; j < 22; j++) begin
         step();
         check_breathe("post_sync");
      end

      // Freeze for 10 clocks, then resume from the held state
      bus.enable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("frozen_led", 32'(bus.led), 32'd0);
         check("frozen_tick", 32'(bus.tick), 32'd0);
      end
      bus.enable = 1'b1;
      for (int j = 0; j < 26; j++) begin
         step();
         check_breathe("resume");
      end
      check("pre_arst_tick", 32'(bus.tick), 32'd1);

      // Async reset while tick is high mid-breathe
      #2 rstN = 1'b0;
      #1;
      check("breathe_arst_led", 32'(bus.led), 32'd0);
      check("breathe_arst_tick", 32'(bus.tick), 32'd0);
      restart_check("breathe_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
